// File: rtl/tuner_pkg.sv
// tuner_pkg: NCO tuning word width shared with tuner, and sweep sequencer state encoding.
package tuner_pkg;
  localparam int FSZ = 26;
  typedef enum logic [1:0] {IDLE, DWELL, DONE} sweep_state_t;
endpackage

// File: rtl/tuner_sweep_settle.sv
// tuner_sweep_settle: holds data_valid low for SETTLE cycles starting on each hop and on reset release.
module tuner_sweep_settle #(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hop,
  output logic data_valid
);
  localparam int SW = $clog2(SETTLE + 1);
  logic [SW-1:0] cnt;
  // Reset loads one extra count so the release cycle behaves like a hop cycle.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= SW'(SETTLE);
    else cnt <= hop ? SW'(SETTLE - 1) : (cnt != '0 ? cnt - 1'b1 : cnt);
  assign data_valid = !hop && cnt == '0;
endmodule

// File: rtl/tuner_sweep_ctrl.sv
// tuner_sweep_ctrl: steps the tuner LO phase-continuously through a programmed sweep.
// Define TUNER_SWEEP_SETTLE_EN to mask data_valid for SETTLE cycles after each hop.
module tuner_sweep_ctrl
  import tuner_pkg::*;
#(
  parameter int FSZ    = tuner_pkg::FSZ,
  parameter int DWSZ   = 16,
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [FSZ-1:0]  cfg_start,
  input  logic [FSZ-1:0]  cfg_stop,
  input  logic [FSZ-1:0]  cfg_step,
  input  logic [DWSZ-1:0] cfg_dwell,
  input  logic            cfg_cont,
  input  logic            cfg_ns_en,
  input  logic            abort,
  output logic [FSZ-1:0]  lo_freq,
  output logic            lo_ns_en,
  output logic            busy,
  output logic            hop,
  output logic            sweep_done,
  output logic            data_valid
);
  sweep_state_t state;
  logic [FSZ-1:0] start_q, stop_q, step_q;
  logic [DWSZ-1:0] reload_q, cnt, dwell_m1;
  logic cont_q, adv;
  logic [FSZ:0] nxt;
  // The extra carry bit marks a step that would pass the top of the tuning range.
  assign nxt = {1'b0, lo_freq} + {1'b0, step_q};
  assign adv = step_q != '0 && !nxt[FSZ] && nxt[FSZ-1:0] <= stop_q;
  assign dwell_m1 = cfg_dwell == '0 ? '0 : cfg_dwell - 1'b1;
  assign cfg_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      start_q <= '0;
      stop_q <= '0;
      step_q <= '0;
      reload_q <= '0;
      cnt <= '0;
      cont_q <= 1'b0;
      lo_freq <= '0;
      lo_ns_en <= 1'b0;
      hop <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      hop <= 1'b0;
      sweep_done <= 1'b0;
      if (state == IDLE) begin
        if (cfg_valid) begin
          start_q <= cfg_start;
          stop_q <= cfg_stop;
          step_q <= cfg_step;
          cont_q <= cfg_cont;
          reload_q <= dwell_m1;
          cnt <= dwell_m1;
          lo_freq <= cfg_start;
          lo_ns_en <= cfg_ns_en;
          hop <= 1'b1;
          state <= DWELL;
        end
      end else if (abort || state == DONE) state <= IDLE;
      else if (cnt != '0) cnt <= cnt - 1'b1;
      else if (adv || cont_q) begin
        lo_freq <= adv ? nxt[FSZ-1:0] : start_q;
        hop <= 1'b1;
        cnt <= reload_q;
      end else begin
        state <= DONE;
        sweep_done <= 1'b1;
      end
    end
`ifdef TUNER_SWEEP_SETTLE_EN
  tuner_sweep_settle #(.SETTLE(SETTLE)) u_settle (
    .clk(clk),
    .reset_n(reset_n),
    .hop(hop),
    .data_valid(data_valid)
  );
`else
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) data_valid <= 1'b0;
    else data_valid <= 1'b1;
`endif
endmodule

// File: tb/tb_tuner_sweep_ctrl.sv
// tb_tuner_sweep_ctrl: table-driven and randomized sweeps checked against a point-list reference model.
module tb_tuner_sweep_ctrl;
  localparam int FSZ = 26;
  localparam int DWSZ = 16;
  localparam int SETTLE = 4;
  localparam longint TOP = 64'd1 << FSZ;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_cont = 1'b0, cfg_ns_en = 1'b0, abort = 1'b0;
  logic [FSZ-1:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0;
  logic [DWSZ-1:0] cfg_dwell = '0;
  logic cfg_ready, lo_ns_en, busy, hop, sweep_done, data_valid;
  logic [FSZ-1:0] lo_freq;

  tuner_sweep_ctrl #(.FSZ(FSZ), .DWSZ(DWSZ), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
    .cfg_cont(cfg_cont), .cfg_ns_en(cfg_ns_en), .abort(abort), .lo_freq(lo_freq),
    .lo_ns_en(lo_ns_en), .busy(busy), .hop(hop), .sweep_done(sweep_done), .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    longint start, stop, step;
    int dwell;
    bit cont, ns, hold;
    int abort_at;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".lo_freq"}, lo_freq, 0);
    chk({tag, ".lo_ns_en"}, lo_ns_en, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".hop"}, hop, 0);
    chk({tag, ".sweep_done"}, sweep_done, 0);
    chk({tag, ".data_valid"}, data_valid, 0);
    chk({tag, ".cfg_ready"}, cfg_ready, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Model: list the visited points, then each cycle c after the handshake maps to a point by c/D.
  task automatic run(input vec_t v, input int id);
    longint pts[$];
    longint nx, e_lo;
    int d, n, a, last, ago;
    bit e_hop, e_done, e_busy, e_dv;
    pts.push_back(v.start);
    nx = v.start + v.step;
    while (v.step != 0 && nx < TOP && nx <= v.stop) begin
      pts.push_back(nx);
      nx += v.step;
    end
    d = v.dwell == 0 ? 1 : v.dwell;
    n = pts.size();
    a = (!v.cont && v.abort_at >= n * d) ? -1 : v.abort_at;
    last = a >= 0 ? a + 1 : n * d + 1;
    ago = 1000;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_start = FSZ'(v.start);
    cfg_stop = FSZ'(v.stop);
    cfg_step = FSZ'(v.step);
    cfg_dwell = DWSZ'(v.dwell);
    cfg_cont = v.cont;
    cfg_ns_en = v.ns;
    abort = 1'b0;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (a >= 0 && c == a + 1) begin
        e_lo = pts[(a / d) % n]; e_hop = 0; e_done = 0; e_busy = 0;
      end else if (!v.cont && c == n * d) begin
        e_lo = pts[n - 1]; e_hop = 0; e_done = 1; e_busy = 1;
      end else if (!v.cont && c == n * d + 1) begin
        e_lo = pts[n - 1]; e_hop = 0; e_done = 0; e_busy = 0;
      end else begin
        e_lo = pts[(c / d) % n]; e_hop = (c % d) == 0; e_done = 0; e_busy = 1;
      end
      ago = e_hop ? 0 : ago + 1;
`ifdef TUNER_SWEEP_SETTLE_EN
      e_dv = ago >= SETTLE;
`else
      e_dv = 1'b1;
`endif
      chk($sformatf("v%0d.c%0d.lo_freq", id, c), lo_freq, e_lo);
      chk($sformatf("v%0d.c%0d.hop", id, c), hop, e_hop);
      chk($sformatf("v%0d.c%0d.sweep_done", id, c), sweep_done, e_done);
      chk($sformatf("v%0d.c%0d.busy", id, c), busy, e_busy);
      chk($sformatf("v%0d.c%0d.cfg_ready", id, c), cfg_ready, !e_busy);
      chk($sformatf("v%0d.c%0d.lo_ns_en", id, c), lo_ns_en, v.ns);
      chk($sformatf("v%0d.c%0d.data_valid", id, c), data_valid, e_dv);
      // Scrambled fields expose any re-latch of the descriptor mid-sweep.
      cfg_valid = v.hold && c < last;
      cfg_start = ~FSZ'(v.start);
      cfg_step = FSZ'(v.step + 3);
      cfg_ns_en = !v.ns;
      abort = c == a;
    end
    cfg_valid = 1'b0;
    abort = 1'b0;
    idle_cycles(6);
  endtask

  initial begin
    vecs.push_back('{start: 100, stop: 130, step: 10, dwell: 3, cont: 0, ns: 1, hold: 0, abort_at: -1});
    vecs.push_back('{start: TOP - 8, stop: TOP - 1, step: 5, dwell: 2, cont: 0, ns: 0, hold: 0, abort_at: -1});
    vecs.push_back('{start: 0, stop: 20, step: 10, dwell: 0, cont: 1, ns: 1, hold: 0, abort_at: 10});
    vecs.push_back('{start: 50, stop: 10, step: 1, dwell: 4, cont: 0, ns: 0, hold: 1, abort_at: -1});
    vecs.push_back('{start: 1000, stop: 1600, step: 100, dwell: 6, cont: 0, ns: 1, hold: 0, abort_at: -1});
    vecs.push_back('{start: 777, stop: 900, step: 0, dwell: 3, cont: 1, ns: 0, hold: 1, abort_at: 11});
    vecs.push_back('{start: 100, stop: 200, step: 10, dwell: 2, cont: 0, ns: 1, hold: 0, abort_at: 5});
    vecs.push_back('{start: TOP - 1, stop: TOP - 1, step: 1, dwell: 1, cont: 1, ns: 1, hold: 0, abort_at: 4});
    for (int i = 0; i < 20; i++) begin
      vec_t v;
      longint st, sp, tmp;
      st = $urandom_range(0, 1) ? longint'($urandom) & (TOP - 1) : TOP - 1 - $urandom_range(0, 3000);
      sp = $urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, 1000);
      tmp = st + sp * $urandom_range(0, 6) + (sp == 0 ? 0 : $urandom_range(0, 32'(sp - 1)));
      if ($urandom_range(0, 7) == 0) tmp = st / 2;
      v.start = st;
      v.step = sp;
      v.stop = tmp > TOP - 1 ? TOP - 1 : tmp;
      v.dwell = $urandom_range(0, 5);
      v.cont = $urandom_range(0, 1);
      v.ns = $urandom_range(0, 1);
      v.hold = $urandom_range(0, 1);
      v.abort_at = v.cont ? int'($urandom_range(0, 30)) :
                   ($urandom_range(0, 3) == 0 ? int'($urandom_range(0, 20)) : -1);
      vecs.push_back(v);
    end

    #2;
    chk_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(SETTLE + 3);

    foreach (vecs[i]) run(vecs[i], i);

    // abort in IDLE is ignored and the same-cycle descriptor is taken
    @(negedge clk);
    cfg_valid = 1'b1; abort = 1'b1;
    cfg_start = 321; cfg_stop = 321; cfg_step = 1; cfg_dwell = 2; cfg_cont = 1; cfg_ns_en = 0;
    @(negedge clk);
    chk("idle_abort.busy", busy, 1);
    chk("idle_abort.hop", hop, 1);
    chk("idle_abort.lo_freq", lo_freq, 321);
    cfg_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    chk("idle_abort.stop_busy", busy, 0);
    chk("idle_abort.lo_hold", lo_freq, 321);
    abort = 1'b0;
    idle_cycles(6);

    // asynchronous reset mid-DWELL
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_start = 5000; cfg_stop = 6000; cfg_step = 100; cfg_dwell = 5; cfg_cont = 0; cfg_ns_en = 1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("midrst.pre_busy", busy, 1);
    chk("midrst.pre_lo", lo_freq, 5000);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(SETTLE + 3);
    chk("midrst.ready_after", cfg_ready, 1);
    run(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tuner_sweep_ctrl.md
# tuner_sweep_ctrl

Sequencer for the tuner NCO. Accepts a sweep descriptor (start, stop, step, dwell) over a valid/ready handshake and drives `lo_freq` and `lo_ns_en` of `tuner` to step the LO through the programmed range. Each step is phase-continuous, because the tuner's phase accumulator is never reset. It emits per-hop and end-of-sweep strobes and a `data_valid` qualifier that masks samples while the mixer pipeline settles.

## Interface
- `FSZ`, 26, NCO tuning word width; must match `tuner`.
- `DWSZ`, 16, dwell counter width.
- `SETTLE`, 4, cycles `data_valid` stays low after each hop; ≥1.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  descriptor valid.
- `cfg_ready`  out  1  descriptor accepted when high with `cfg_valid`.
- `cfg_start`  in  FSZ  first tuning word.
- `cfg_stop`  in  FSZ  last permitted tuning word.
- `cfg_step`  in  FSZ  unsigned increment per hop.
- `cfg_dwell`  in  DWSZ  cycles per frequency; 0 is treated as 1.
- `cfg_cont`  in  1  0 = single sweep, 1 = restart at start indefinitely.
- `cfg_ns_en`  in  1  noise-shaping enable, latched with the descriptor.
- `abort`  in  1  terminate the active sweep.
- `lo_freq`  out  FSZ  to `tuner.lo_freq`.
- `lo_ns_en`  out  1  to `tuner.lo_ns_en`.
- `busy`  out  1  sweep active.
- `hop`  out  1  1-cycle pulse on the cycle `lo_freq` takes a new value.
- `sweep_done`  out  1  1-cycle pulse at the natural end of a single sweep.
- `data_valid`  out  1  tuner output qualifier.

## Operation
- States: IDLE, DWELL, DONE. `cfg_ready` = (state == IDLE). `busy` = (state != IDLE).
- IDLE:
  - On handshake, latch the descriptor.
  - Next cycle: `lo_freq`←`cfg_start`, `lo_ns_en`←`cfg_ns_en`, `hop`=1, load the dwell counter with max(`cfg_dwell`,1)−1, go to DWELL.
- DWELL: the counter decrements each cycle. At zero:
  - Compute `next` = `lo_freq` + `step` at FSZ+1 bits.
  - If `step`≠0, `next[FSZ]`=0 and `next`≤`stop`: set `lo_freq`←`next`, `hop`=1, reload the counter.
  - Otherwise the sweep has reached its last point:
    - Continuous mode: `lo_freq`←`start`, `hop`=1, reload the counter.
    - Single mode: go to DONE.
- DONE: `sweep_done`=1 for one cycle, then IDLE.
- Every frequency, including the last, is held exactly max(`cfg_dwell`,1) cycles.
- `start`>`stop`: one point at `start`, then end or restart. `step`=0: fixed tune at `start`, with the dwell-period restart hop in continuous mode.
- Carry out of FSZ bits counts as passing `stop`; the word never wraps.
- `abort` in DWELL or DONE: next state is IDLE, `sweep_done` is not pulsed, and `lo_freq`/`lo_ns_en` hold. `abort` in IDLE is ignored; a same-cycle `cfg_valid` is still accepted.
- In IDLE, `lo_freq` and `lo_ns_en` hold their last values (the tuner keeps running).

## Timing
- Reset values:
  - State IDLE, so `cfg_ready`=1.
  - `lo_freq`=0, `lo_ns_en`=0, `busy`=0, `hop`=0, `sweep_done`=0, `data_valid`=0.
- Handshake at cycle T → `lo_freq`=`start` and `hop`=1 at T+1. The next hop is at T+1+D, where D = max(`cfg_dwell`,1).
- Single sweep of N points: `sweep_done` at T+1+N·D, and `cfg_ready` returns at T+2+N·D.
- All outputs are registered; there are no combinational paths from inputs to outputs except `cfg_ready` (state-decoded).
- `reset_n` asserted mid-sweep: all outputs take their reset values immediately (asynchronous); the descriptor is discarded.

## Configuration
- `TUNER_SWEEP_SETTLE_EN` defined:
  - `data_valid` drops on the cycle of each `hop`. It returns high SETTLE cycles later unless another hop intervenes, in which case the count restarts.
  - Reset release is treated as a hop.
  - If D ≤ SETTLE, `data_valid` stays low for the whole sweep.
- `TUNER_SWEEP_SETTLE_EN` undefined:
  - `data_valid` is 0 during reset and 1 from the first cycle after reset release.
  - `SETTLE` is unused.

## Structure
- `tuner_pkg`: the FSZ constant (shared with `tuner`) and the state encoding (IDLE/DWELL/DONE).
- Sub-module `tuner_sweep_settle` holds the settle counter and `data_valid` generation, instantiated only under `TUNER_SWEEP_SETTLE_EN`.

## Test plan
- Start=100, stop=130, step=10, dwell=3, single: `lo_freq` 100/110/120/130 each held 3 cycles, 4 `hop` pulses; `sweep_done` 12 cycles after the first hop; `lo_freq` holds 130.
- Start=2^26−8, stop=2^26−1, step=5, dwell=2, single: two points (2^26−8, 2^26−3), no wrap, then `sweep_done`.
- Start=0, stop=20, step=10, dwell=0, cont: hops every cycle with sequence 0,10,20,0,10…; `sweep_done` never pulses; `abort` → IDLE next cycle, `lo_freq` frozen, no `sweep_done`.
- Start=50, stop=10, step=1, dwell=4, single: one point at 50 for 4 cycles, then `sweep_done`; `cfg_valid` held high during the sweep is accepted only in IDLE.
- With SETTLE_EN, SETTLE=4, dwell=6: `data_valid` low on each hop cycle plus 3 following cycles, high for the remaining 2 cycles of each dwell.
- `reset_n` low mid-DWELL: all outputs return to their reset values without waiting for a clock edge; after release, `cfg_ready`=1 and the next descriptor sweeps normally.
